// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter sequencer and its return stack.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the next-PC select codes and the RUN/HALT state encoding.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_CALL   = 2'b10,
        SEL_RET    = 2'b11
    } sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; push writes above the top entry, pop drops the top entry.
// Latency: count/data update on the falling clock edge after push/pop.
// Backpressure: none; the caller must not push when full or pop when empty.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q = '0;
    logic [CW-1:0]    top_idx;

    assign top_idx = count_q - CW'(1);
    assign count   = count_q;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign data    = empty ? '0 : mem[top_idx[IW-1:0]];

    // Storage itself is never reset: entries above count are dead.
    always_ff @(negedge clk) begin
        if (push && !full) begin
            mem[count_q[IW-1:0]] <= push_data;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CW'(1);
        end else if (pop && !empty) begin
            count_q <= top_idx;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/call/return with RUN/HALT control; return stack under PC_CALL_STACK_EN.
// Latency: selection sampled at a falling edge shows on program_count right after that edge.
// Backpressure: enable=0 stalls all state; no handshake.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                LENGTH      = 11,
    parameter int                STACK_DEPTH = 4,
    parameter logic [LENGTH-1:0] RESET_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [1:0]                       sel,
    input  logic [LENGTH-1:0]                target,
    input  logic                             halt,
    input  logic                             resume,
    output logic [LENGTH-1:0]                program_count,
    output logic                             halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             stack_overflow,
    output logic                             stack_underflow
);

    state_e            state_q = ST_RUN;
    state_e            state_d;
    logic [LENGTH-1:0] pc_q    = RESET_ADDR;
    logic [LENGTH-1:0] pc_d;
    logic [LENGTH-1:0] pc_inc;

    assign pc_inc        = pc_q + LENGTH'(1);
    assign program_count = pc_q;
    assign halted        = (state_q == ST_HALT);

`ifdef PC_CALL_STACK_EN
    logic              push;
    logic              pop;
    logic              set_ovf;
    logic              set_unf;
    logic              stk_full;
    logic              stk_empty;
    logic [LENGTH-1:0] stk_top;
    logic              ovf_q = 1'b0;
    logic              unf_q = 1'b0;

    pc_return_stack #(
        .WIDTH (LENGTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .data      (stk_top),
        .count     (stack_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

    always_ff @(negedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | set_ovf;
            unf_q <= unf_q | set_unf;
        end
    end
`else
    assign stack_count     = '0;
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;
`endif

    // Halt takes priority over any PC selection; in HALT only resume matters.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_CALL_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
`endif
        if (enable) begin
            if (state_q == ST_HALT) begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end else if (halt) begin
                state_d = ST_HALT;
            end else begin
                case (sel_e'(sel))
                    SEL_SEQ:    pc_d = pc_inc;
                    SEL_BRANCH: pc_d = target;
`ifdef PC_CALL_STACK_EN
                    SEL_CALL: begin
                        pc_d = target;
                        if (stk_full) begin
                            set_ovf = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                    SEL_RET: begin
                        if (stk_empty) begin
                            pc_d    = pc_inc;
                            set_unf = 1'b1;
                        end else begin
                            pc_d = stk_top;
                            pop  = 1'b1;
                        end
                    end
`else
                    SEL_CALL:   pc_d = target;
                    SEL_RET:    pc_d = pc_inc;
`endif
                endcase
            end
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a queue-based reference model, plus directed scenarios.
// A second small instance covers narrow-width wrap and a non-zero reset address.
module tb_pc_sequencer;

`ifdef PC_CALL_STACK_EN
    localparam bit HAS_STACK = 1'b1;
`else
    localparam bit HAS_STACK = 1'b0;
`endif
    localparam int DEPTH = 4;
    localparam int PC_MASK = 32'h7FF;

    logic        clk = 1'b0;
    logic        reset = 1'b0, enable = 1'b0, halt = 1'b0, resume = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [10:0] target = '0;
    logic [10:0] program_count;
    logic        halted, stack_overflow, stack_underflow;
    logic [2:0]  stack_count;

    logic        s_reset = 1'b0, s_enable = 1'b0;
    logic [1:0]  s_sel = 2'b00;
    logic [3:0]  s_target = '0;
    logic [3:0]  s_pc;
    logic        s_halted, s_ovf, s_unf;
    logic [1:0]  s_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned m_pc = 0;
    bit          m_halt = 1'b0;
    bit          m_ovf = 1'b0, m_unf = 1'b0;
    int unsigned m_stk[$];

    always #5 clk = ~clk;

    pc_sequencer #(.LENGTH(11), .STACK_DEPTH(DEPTH), .RESET_ADDR(11'd0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sel(sel), .target(target),
        .halt(halt), .resume(resume), .program_count(program_count), .halted(halted),
        .stack_count(stack_count), .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    pc_sequencer #(.LENGTH(4), .STACK_DEPTH(2), .RESET_ADDR(4'd3)) dut_small (
        .clk(clk), .reset(s_reset), .enable(s_enable), .sel(s_sel), .target(s_target),
        .halt(1'b0), .resume(1'b0), .program_count(s_pc), .halted(s_halted),
        .stack_count(s_count), .stack_overflow(s_ovf), .stack_underflow(s_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input bit rst, input bit en, input bit [1:0] s,
                                       input int unsigned t, input bit h, input bit r);
        if (rst) begin
            m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else if (en) begin
            if (m_halt) begin
                if (r) m_halt = 0;
            end else if (h) begin
                m_halt = 1;
            end else if (s == 2'd0) begin
                m_pc = (m_pc + 1) & PC_MASK;
            end else if (s == 2'd1) begin
                m_pc = t;
            end else if (s == 2'd2) begin
                if (HAS_STACK) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) & PC_MASK);
                    else m_ovf = 1;
                end
                m_pc = t;
            end else begin
                if (HAS_STACK && m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc = (m_pc + 1) & PC_MASK;
                    if (HAS_STACK) m_unf = 1;
                end
            end
        end
    endfunction

    task automatic cyc(input bit rst, input bit en, input bit [1:0] s,
                       input bit [10:0] t, input bit h, input bit r);
        reset = rst; enable = en; sel = s; target = t; halt = h; resume = r;
        @(negedge clk);
        #1;
        model_step(rst, en, s, t, h, r);
        check("pc",        program_count,   m_pc);
        check("halted",    halted,          m_halt);
        check("stack_cnt", stack_count,     m_stk.size());
        check("ovf",       stack_overflow,  m_ovf);
        check("unf",       stack_underflow, m_unf);
    endtask

    task automatic scyc(input bit rst, input bit en, input bit [1:0] s, input bit [3:0] t);
        s_reset = rst; s_enable = en; s_sel = s; s_target = t;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Power-up values before any edge
        #1;
        check("pwrup_pc",  program_count, 0);
        check("pwrup_hlt", halted, 0);
        check("pwrup_cnt", stack_count, 0);
        check("pwrup_flg", {stack_overflow, stack_underflow}, 0);
        check("pwrup_spc", s_pc, 3);

        // Reset, counting, stall
        cyc(1, 1, 2'd1, 11'h55, 1, 0);
        check("rst_pc", program_count, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 2'd0, 0, 0, 0);
            check("seq_pc", program_count, i);
        end
        cyc(0, 0, 2'd1, 11'h77, 1, 0);
        cyc(0, 0, 2'd2, 11'h22, 0, 0);
        check("stall_pc", program_count, 3);

        // Call and return
        cyc(0, 1, 2'd1, 11'h5, 0, 0);
        cyc(0, 1, 2'd2, 11'h40, 0, 0);
        check("call_pc",  program_count, 'h40);
        check("call_cnt", stack_count, HAS_STACK ? 1 : 0);
        cyc(0, 1, 2'd3, 0, 0, 0);
        check("ret_pc",  program_count, HAS_STACK ? 6 : 'h41);
        check("ret_cnt", stack_count, 0);

        // Five calls then five returns
        for (int i = 0; i < 5; i++) cyc(0, 1, 2'd2, 11'h100 + 11'(i * 16), 0, 0);
        check("ovf_cnt", stack_count, HAS_STACK ? 4 : 0);
        check("ovf_flag", stack_overflow, HAS_STACK);
        for (int i = 0; i < 5; i++) cyc(0, 1, 2'd3, 0, 0, 0);
        check("unf_flag", stack_underflow, HAS_STACK);

        // Halt wins over branch; resume holds PC; then sequential
        cyc(0, 1, 2'd1, 11'h10, 1, 0);
        check("halt_h", halted, 1);
        cyc(0, 1, 2'd1, 11'h33, 0, 0);
        cyc(0, 0, 2'd0, 0, 0, 1);
        cyc(0, 1, 2'd0, 0, 0, 1);
        check("resume_h", halted, 0);
        cyc(0, 1, 2'd0, 0, 0, 0);

        // Reset during HALT with two stacked entries
        cyc(0, 1, 2'd2, 11'h200, 0, 0);
        cyc(0, 1, 2'd2, 11'h300, 0, 0);
        cyc(0, 1, 2'd0, 0, 1, 0);
        cyc(1, 0, 2'd0, 0, 0, 0);
        check("rsth_pc",  program_count, 0);
        check("rsth_cnt", stack_count, 0);
        cyc(0, 1, 2'd3, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 11'($urandom), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) == 0));
        end

        // Narrow instance: non-zero reset address and 4-bit wrap
        scyc(1, 0, 2'd0, 0);
        check("s_rst", s_pc, 3);
        scyc(0, 1, 2'd1, 4'hF);
        check("s_br", s_pc, 15);
        scyc(0, 1, 2'd0, 0);
        check("s_wrap", s_pc, 0);
        check("s_flags", {s_ovf, s_unf, s_halted}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter LENGTH, default 11, SHALL set the program-count width in bits.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the return-stack entry count (range 2..16).
REQ-003 Parameter RESET_ADDR, default 0, SHALL set the program_count value loaded on reset.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its falling edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 enable  in  1  SHALL gate every state change; 0 = stall.
REQ-007 sel  in  2  SHALL select the next PC: 00 sequential, 01 branch, 10 call, 11 return.
REQ-008 target  in  LENGTH  SHALL carry the branch/call destination.
REQ-009 halt  in  1  SHALL request entry to HALT.
REQ-010 resume  in  1  SHALL request exit from HALT.
REQ-011 program_count  out  LENGTH  SHALL be the registered current PC.
REQ-012 halted  out  1  SHALL be 1 while in HALT.
REQ-013 stack_count  out  clog2(STACK_DEPTH+1)  SHALL give the number of valid return-stack entries.
REQ-014 stack_overflow  out  1  SHALL be a sticky flag for a call on a full stack.
REQ-015 stack_underflow  out  1  SHALL be a sticky flag for a return on an empty stack.

Function
REQ-016 FSM states SHALL be RUN and HALT; in RUN with enable=1 and halt=1: go to HALT and leave PC and stack unchanged (halt wins over sel).
REQ-017 In HALT with enable=1 and resume=1: go to RUN with no PC change that edge; in HALT, sel is ignored.
REQ-018 With enable=0: PC, stack, flags and FSM state SHALL hold; halt/resume are ignored.
REQ-019 RUN, sel=00: PC <= PC+1 modulo 2^LENGTH (all-ones wraps to 0, no flag).
REQ-020 RUN, sel=01: PC <= target.
REQ-021 RUN, sel=10: push PC+1 (modulo 2^LENGTH) and PC <= target; on full stack: drop the push, contents unchanged, PC <= target, stack_overflow <= 1.
REQ-022 RUN, sel=11: PC <= top entry and pop; on empty stack: PC <= PC+1, stack_underflow <= 1.
REQ-023 Latency: a selection sampled at falling edge N SHALL be visible on program_count immediately after edge N.
REQ-024 Overflow/underflow flags SHALL clear only on reset.

Reset
REQ-025 Reset SHALL dominate enable and all other inputs.
REQ-026 On reset: program_count=RESET_ADDR, state RUN, halted=0, stack_count=0, both flags 0.
REQ-027 Reset mid-call or mid-halt SHALL discard all stack contents.
REQ-028 Power-up (initial) values SHALL equal reset values.

Configuration
REQ-029 Macro PC_CALL_STACK_EN SHALL compile in the return stack.
REQ-030 With PC_CALL_STACK_EN defined: REQ-021 and REQ-022 apply.
REQ-031 Without PC_CALL_STACK_EN: sel=10 acts as branch and sel=11 as sequential; stack_count, stack_overflow and stack_underflow are tied to 0; no stack storage is built.

Structure
REQ-032 Shared package pc_pkg SHALL hold the sel encodings (SEL_SEQ, SEL_BRANCH, SEL_CALL, SEL_RET) and the RUN/HALT state encoding.
REQ-033 The LIFO SHALL be a sub-module, pc_return_stack (push, pop, data, count, full, empty), instantiated only under PC_CALL_STACK_EN.

Verification
REQ-034 Reset, then 3 edges with sel=00 and enable=1 -> program_count 0,1,2,3; with enable=0 -> holds at 3.
REQ-035 LENGTH=4, PC=15, sel=00 -> PC=0, no flag set.
REQ-036 PC=5, call target=0x40, then return -> PC 0x40, then 6, stack_count 1 then 0.
REQ-037 STACK_DEPTH=4: five calls -> stack_count=4, stack_overflow=1; five returns -> fifth gives underflow=1 and PC=last PC+1.
REQ-038 halt=1 with sel=01 target=0x10 -> halted=1, PC unchanged; resume=1 -> halted=0, PC unchanged; next sel=00 -> PC+1.
REQ-039 Reset asserted in HALT with 2 stacked entries -> PC=RESET_ADDR, halted=0, stack_count=0, flags 0.
